fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage: owns the PC register enable, next-PC source select and the F/D and D/E pipeline flush/stall controls. It sits between the hazard sources (execute-stage control transfers, decode load-use detection, instruction-cache miss/ready) and the PC datapath (`pc_reg` + `pc_mux`). It also gates start-up so the PC does not advance after reset until `trigger` is seen.

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/fetch_ctrl_sat_counter.sv | 38 +++
 rtl/fetch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the fetch-stage sequencing controller and the
// PC datapath (pc_reg + pc_mux).
//   fetch_state_t : controller FSM state (IDLE / RUN / MISS), 2'b11 unused
//   pcsrc_t       : next-PC select driven into pc_mux, 2'b11 never driven
//   RST_*         : values the controller presents right after reset
//   redirect_src  : picks the next-PC source for an execute-stage redirect
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_RUN  = 2'b01,
    FS_MISS = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,  // sequential fetch
    PC_TARGET = 2'b01,  // pce + immexte (branch / jal)
    PC_ALU    = 2'b10   // aluresult (jalr)
  } pcsrc_t;

  // Reset / IDLE presentation: PC held, both pipeline registers flushed.
  localparam fetch_state_t RST_STATE   = FS_IDLE;
  localparam pcsrc_t       RST_PCSRC   = PC_PLUS4;
  localparam logic         RST_EN_B    = 1'b0;
  localparam logic         RST_STALL_D = 1'b0;
  localparam logic         RST_FLUSH_D = 1'b1;
  localparam logic         RST_FLUSH_E = 1'b1;

  // jalr takes its target from the ALU; branch and jal use pce + immexte.
  // jalr wins if it is (illegally) asserted together with another redirect.
  function automatic pcsrc_t redirect_src(input logic jalr_e);
    return jalr_e ? PC_ALU : PC_TARGET;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : increment enable (ignored once the count reaches all-ones)
//   count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch-stage sequencing controller. Drives the PC register enable, the
// next-PC source select and the F/D, D/E stall/flush controls from the hazard
// sources. Outputs are Mealy: combinational from state plus current inputs.
// After reset the PC is held until trigger is seen in IDLE.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   trigger             : start request (IDLE only)
//   icache_miss         : fetch address missed this cycle
//   icache_ready        : miss fill complete, instruction valid this cycle
//   loaduse_hazard      : decode-stage load-use hazard
//   branch_taken_e      : execute-stage taken branch
//   jump_e, jalr_e      : execute-stage jal / jalr
//   en_b                : PC load enable (1 = load next_pc)
//   pcsrc               : next-PC select (pcsrc_t)
//   stall_d             : hold F/D register
//   flush_d, flush_e    : bubble F/D, D/E at next edge
//   fetch_state         : current FSM state (debug)
//   perf_stall_cycles   : cycles with PC held outside IDLE   (FETCH_PERF_EN)
//   perf_redirects      : execute-stage redirect cycles      (FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the two saturating perf counters.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 icache_miss,
  input  logic                 icache_ready,
  input  logic                 loaduse_hazard,
  input  logic                 branch_taken_e,
  input  logic                 jump_e,
  input  logic                 jalr_e,
  output logic                 en_b,
  output pcsrc_t               pcsrc,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [1:0]           fetch_state
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [CNT_WIDTH-1:0] perf_redirects
`endif
);

  fetch_state_t state_reg;
  fetch_state_t state_next;
  logic         redirect;

  assign redirect = jalr_e | jump_e | branch_taken_e;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RST_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The unused encoding behaves exactly like IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_RUN: begin
        if (redirect) begin
          state_next = FS_RUN;
        end else if (icache_miss) begin
          state_next = FS_MISS;
        end else begin
          state_next = FS_RUN;
        end
      end
      FS_MISS: begin
        // A redirect aborts the outstanding fill: it was on the wrong path.
        if (redirect || icache_ready) begin
          state_next = FS_RUN;
        end else begin
          state_next = FS_MISS;
        end
      end
      default: begin
        state_next = trigger ? FS_RUN : FS_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    en_b    = RST_EN_B;
    pcsrc   = RST_PCSRC;
    stall_d = RST_STALL_D;
    flush_d = RST_FLUSH_D;
    flush_e = RST_FLUSH_E;
    case (state_reg)
      FS_RUN: begin
        if (redirect) begin
          // Miss / load-use on the same cycle belong to the wrong path.
          en_b    = 1'b1;
          pcsrc   = redirect_src(jalr_e);
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (icache_miss) begin
          en_b    = 1'b0;
          flush_d = 1'b1;
          flush_e = 1'b0;
        end else if (loaduse_hazard) begin
          en_b    = 1'b0;
          stall_d = 1'b1;
          flush_d = 1'b0;
          flush_e = 1'b1;
        end else begin
          en_b    = 1'b1;
          flush_d = 1'b0;
          flush_e = 1'b0;
        end
      end
      FS_MISS: begin
        if (redirect) begin
          en_b    = 1'b1;
          pcsrc   = redirect_src(jalr_e);
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          en_b    = icache_ready;
          flush_d = ~icache_ready;
          flush_e = 1'b0;
          // A stalled F/D register holds the older instruction; clearing it
          // would lose that instruction, so the stall overrides the bubble.
          if (loaduse_hazard) begin
            stall_d = 1'b1;
            flush_d = 1'b0;
            flush_e = 1'b1;
          end
        end
      end
      default: begin
        // IDLE (and unused encoding): reset presentation, hazards ignored.
      end
    endcase
  end

  assign fetch_state = state_reg;

`ifdef FETCH_PERF_EN
  logic                 active;
  logic [1:0]           perf_inc;
  logic [CNT_WIDTH-1:0] perf_count [2];

  assign active      = (state_reg == FS_RUN) || (state_reg == FS_MISS);
  assign perf_inc[0] = active && !en_b;
  assign perf_inc[1] = active && redirect;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      sat_counter #(
        .WIDTH(CNT_WIDTH)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (perf_inc[gi]),
        .count(perf_count[gi])
      );
    end
  endgenerate

  assign perf_stall_cycles = perf_count[0];
  assign perf_redirects    = perf_count[1];
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed testbench for fetch_ctrl. Inputs change 1 time unit after the
// rising edge; Mealy outputs are compared mid-cycle. Perf-counter comparisons
// are present only when FETCH_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        icache_miss;
  logic        icache_ready;
  logic        loaduse_hazard;
  logic        branch_taken_e;
  logic        jump_e;
  logic        jalr_e;
  logic        en_b;
  logic [1:0]  pcsrc;
  logic        stall_d;
  logic        flush_d;
  logic        flush_e;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cycles;
  logic [15:0] perf_redirects;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .CNT_WIDTH(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .trigger          (trigger),
    .icache_miss      (icache_miss),
    .icache_ready     (icache_ready),
    .loaduse_hazard   (loaduse_hazard),
    .branch_taken_e   (branch_taken_e),
    .jump_e           (jump_e),
    .jalr_e           (jalr_e),
    .en_b             (en_b),
    .pcsrc            (pcsrc),
    .stall_d          (stall_d),
    .flush_d          (flush_d),
    .flush_e          (flush_e),
    .fetch_state      (fetch_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects   (perf_redirects)
`endif
  );

  // jalr together with another redirect is illegal; the bench never drives it.
  always @(posedge clk) begin
    assert (!(jalr_e && (jump_e || branch_taken_e)))
      else $error("illegal jalr_e with jump_e/branch_taken_e");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock: inputs may be changed right after return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before comparing.
  task automatic settle();
    #3;
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] st, input logic eb,
                           input logic [1:0] src, input logic sd, input logic fd,
                           input logic fe);
    check({tag, ".state"},   fetch_state, st);
    check({tag, ".en_b"},    en_b,        eb);
    check({tag, ".pcsrc"},   pcsrc,       src);
    check({tag, ".stall_d"}, stall_d,     sd);
    check({tag, ".flush_d"}, flush_d,     fd);
    check({tag, ".flush_e"}, flush_e,     fe);
  endtask

  task automatic clear_inputs();
    trigger        = 1'b0;
    icache_miss    = 1'b0;
    icache_ready   = 1'b0;
    loaduse_hazard = 1'b0;
    branch_taken_e = 1'b0;
    jump_e         = 1'b0;
    jalr_e         = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // ---- start-up: 2 reset cycles, 3 idle cycles, 1 trigger cycle ----
    #1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check_ctl("reset", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
`ifdef FETCH_PERF_EN
    check("reset.perf_stall", perf_stall_cycles, 0);
    check("reset.perf_redir", perf_redirects, 0);
`endif
    // Hazards are ignored in IDLE.
    for (int i = 0; i < 3; i++) begin
      tick();
      icache_miss = 1'b1;
      jump_e      = 1'b1;
      settle();
      check_ctl($sformatf("idle%0d", i), 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    end
    tick();
    clear_inputs();
    trigger = 1'b1;
    settle();
    check("trig.en_b", en_b, 1'b0);
    tick();
    trigger = 1'b0;
    settle();
    check_ctl("run0", 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    // ---- miss: miss cycle + 3 wait cycles, ready on the 4th after ----
    tick();
    icache_miss = 1'b1;
    settle();
    check_ctl("miss_run", 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    icache_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_ctl($sformatf("miss_wait%0d", i), 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
    end
    icache_ready = 1'b1;
    settle();
    check_ctl("miss_ready", 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    icache_ready = 1'b0;
    settle();
    check("miss_after.state", fetch_state, 2'b01);
`ifdef FETCH_PERF_EN
    check("miss.perf_stall", perf_stall_cycles, 4);
`endif

    // ---- redirect priority: jalr + miss + load-use together ----
    tick();
    jalr_e         = 1'b1;
    icache_miss    = 1'b1;
    loaduse_hazard = 1'b1;
    settle();
    check_ctl("redir_pri", 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    clear_inputs();
    settle();
    check("redir_pri_after.state", fetch_state, 2'b01);
`ifdef FETCH_PERF_EN
    check("redir_pri.perf_redir", perf_redirects, 1);
    check("redir_pri.perf_stall", perf_stall_cycles, 4);
`endif

    // ---- jal in RUN selects TARGET ----
    tick();
    jump_e = 1'b1;
    settle();
    check_ctl("jal_run", 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);

    // ---- redirect during MISS wait ----
    tick();
    clear_inputs();
    icache_miss = 1'b1;
    tick();
    icache_miss = 1'b0;
    settle();
    check("rmiss_wait.state", fetch_state, 2'b10);
    tick();
    branch_taken_e = 1'b1;
    settle();
    check_ctl("rmiss_branch", 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
    tick();
    branch_taken_e = 1'b0;
    settle();
    check("rmiss_after.state", fetch_state, 2'b01);
`ifdef FETCH_PERF_EN
    // stalls: 4 + miss cycle + one wait cycle; redirects: jalr, jal, branch
    check("rmiss.perf_stall", perf_stall_cycles, 6);
    check("rmiss.perf_redir", perf_redirects, 3);
`endif

    // ---- load-use for one cycle in RUN ----
    tick();
    loaduse_hazard = 1'b1;
    settle();
    check_ctl("lu", 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    loaduse_hazard = 1'b0;
    settle();
    check_ctl("lu_after", 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    // ---- load-use during MISS: stall wins over the F/D bubble ----
    tick();
    icache_miss = 1'b1;
    tick();
    icache_miss    = 1'b0;
    loaduse_hazard = 1'b1;
    settle();
    check_ctl("lu_miss", 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    loaduse_hazard = 1'b0;
    settle();
    check("lu_miss_hold.state", fetch_state, 2'b10);
`ifdef FETCH_PERF_EN
    // 6 + load-use + miss cycle + load-use-in-miss cycle
    check("lu.perf_stall", perf_stall_cycles, 9);
`endif

    // ---- reset mid-miss ----
    rst = 1'b1;
    tick();
    settle();
    check_ctl("rst_miss", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
`ifdef FETCH_PERF_EN
    check("rst_miss.perf_stall", perf_stall_cycles, 0);
    check("rst_miss.perf_redir", perf_redirects, 0);
`endif

    // ---- rst has priority over trigger ----
    tick();
    trigger = 1'b1;
    tick();
    settle();
    check("rst_trig.state", fetch_state, 2'b00);
    rst = 1'b0;
    tick();
    trigger = 1'b0;
    settle();
    check_ctl("restart", 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    // ---- trigger in RUN is ignored ----
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    settle();
    check("trig_run.state", fetch_state, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the directed sequence is a few dozen cycles.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
